instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly downstream of `program_counter2`. Samples the current PC, issues a single-outstanding request to instruction memory, and loads the returned word into the IF/ID pipeline register. Pulses `pc_advance` back to the program counter when a fetch retires. Handles decode back-pressure, pipeline flush, misaligned PCs and memory timeout.

## Interface
- `TIMEOUT`, 16: max cycles `imem_req` may stay high without `imem_ready` before a fault.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  [0:31]  current PC from `program_counter2`.
- `pc_advance`  out  1  one-cycle pulse; the PC may step to the next address.
- `imem_req`  out  1  memory request; held until `imem_ready`.
- `imem_addr`  out  [0:31]  request address; stable while `imem_req`=1.
- `imem_data`  in  [0:31]  instruction word; valid in the cycle `imem_ready`=1.
- `imem_ready`  in  1  transaction complete; sampled only while `imem_req`=1.
- `id_stall`  in  1  decode cannot accept; IF/ID must hold.
- `flush`  in  1  discard in-flight and buffered instructions.
- `if_valid`  out  1  IF/ID holds a valid instruction.
- `if_instr`  out  [0:31]  fetched instruction.
- `if_pc`  out  [0:31]  address of `if_instr`.
- `fetch_err`  out  1  sticky fault flag.
- `err_pc`  out  [0:31]  faulting address.

## Operation
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- Decode consumes IF/ID when `if_valid`=1 and `id_stall`=0. On that edge `if_valid` clears unless a new word is loaded.
- IF/ID may be loaded when `if_valid`=0 or `id_stall`=0. Call this condition "space".
- IDLE, `flush`=0, `pc[30:31]`=00: set `imem_addr`<=`pc`, `imem_req`<=1, go to WAIT.
- IDLE, `pc[30:31]`≠00: set `err_pc`<=`pc`, `fetch_err`<=1, go to ERR. No request is issued.
- WAIT, `imem_ready`=1, space: set `imem_req`<=0, `if_instr`<=`imem_data`, `if_pc`<=`imem_addr`, `if_valid`<=1, `pc_advance`<=1, go to IDLE.
- WAIT, `imem_ready`=1, no space: capture the word and address into the hold buffer, set `imem_req`<=0, go to HOLD.
- HOLD, space: load IF/ID from the buffer, `pc_advance`<=1, go to IDLE.
- DRAIN: keep `imem_req` high. On `imem_ready`, discard the data, set `imem_req`<=0, go to IDLE. No `pc_advance`.
- ERR: terminal until `rst`. No requests are issued. An IF/ID entry already present drains normally.
- `flush` has top priority on any edge: `if_valid`<=0 and `pc_advance`<=0.
  - WAIT without ready goes to DRAIN.
  - WAIT with ready goes to IDLE and drops the data.
  - HOLD goes to IDLE and drops the buffer.
  - IDLE stays IDLE; no request on that edge.
  - ERR is unaffected.
- Timeout: `wait_cnt` clears on each request and counts cycles with `imem_req`=1 and `imem_ready`=0, in WAIT or DRAIN. When it reaches `TIMEOUT`: `imem_req`<=0, `err_pc`<=`imem_addr`, `fetch_err`<=1, go to ERR.

## Timing
- PC sampled at edge N; `imem_req` is high in cycle N+1.
- With zero-wait memory (ready in N+1), `if_valid` and `pc_advance` are high in N+2.
- Steady-state throughput is one fetch per 2 cycles. Each extra wait cycle adds 1.
- `pc_advance` is exactly one cycle wide, one pulse per retired fetch. It is never asserted for dropped or faulted fetches.
- `imem_addr` changes only on the edge that raises `imem_req`.
- Reset mid-transaction clears `imem_req` asynchronously. The memory must tolerate an abandoned request.

## Structure
- Shared include `fetch_defs.v` holds:
  - state encodings: IDLE, WAIT, HOLD, DRAIN, ERR;
  - the default `TIMEOUT`;
  - `INSTR_W`=32.
- Sub-module `if_id_reg` holds the IF/ID register: load, hold on stall, clear on flush, async reset.
- The FSM, hold buffer and `wait_cnt` live in `instr_fetch`.

## Test plan
- Zero-wait memory, `pc`=200, no stall:
  - `imem_req`/`imem_addr`=200 in N+1;
  - `if_valid`=1, `if_pc`=200, `if_instr`=mem[200], `pc_advance` pulse in N+2.
- Stall: `id_stall`=1 with `if_valid`=1 while the next fetch returns.
  - FSM enters HOLD; IF/ID unchanged.
  - On stall release, IF/ID loads the buffered word in the next cycle with one `pc_advance`.
- Flush during a 3-wait-cycle fetch of `pc`=204:
  - `imem_req` stays high until ready, then the data is dropped;
  - no `pc_advance`; `if_valid`=0; a new fetch is issued after DRAIN→IDLE.
- Misaligned `pc`=202: no `imem_req`; `fetch_err`=1, `err_pc`=202 next cycle; stays set until `rst`.
- `imem_ready` held 0: `fetch_err`=1 after 16 cycles of `imem_req`, `err_pc`=`imem_addr`, `imem_req` drops.
- Assert `rst` mid-WAIT: all outputs 0 immediately. After release, the fetch restarts from the current `pc`.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encodings,
// instruction width and the default memory timeout.
package instr_fetch_pkg;
  localparam int INSTR_W     = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds while decode stalls,
// empties on flush or when decode consumes it.
module if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [INSTR_W-1:0] i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_pc
);
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (!i_stall) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding memory request, hold buffer for
// decode back-pressure, flush drain, misalignment and timeout fault capture.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] i_pc,
  output logic               o_pc_advance,
  output logic               o_imem_req,
  output logic [INSTR_W-1:0] o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_data,
  input  logic               i_imem_ready,
  input  logic               i_id_stall,
  input  logic               i_flush,
  output logic               o_if_valid,
  output logic [INSTR_W-1:0] o_if_instr,
  output logic [INSTR_W-1:0] o_if_pc,
  output logic               o_fetch_err,
  output logic [INSTR_W-1:0] o_err_pc
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  fetch_state_t       r_state, w_state_n;
  logic               r_req, w_req_n;
  logic [INSTR_W-1:0] r_addr, w_addr_n;
  logic               r_adv, w_adv_n;
  logic               r_err, w_err_n;
  logic [INSTR_W-1:0] r_err_pc, w_err_pc_n;
  logic [INSTR_W-1:0] r_buf_instr, w_buf_instr_n;
  logic [INSTR_W-1:0] r_buf_pc, w_buf_pc_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_load;
  logic [INSTR_W-1:0] w_load_instr;
  logic [INSTR_W-1:0] w_load_pc;
  logic               w_space;
  logic               w_if_valid;

  assign w_space   = !w_if_valid || !i_id_stall;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_adv       <= 1'b0;
      r_err       <= 1'b0;
      r_err_pc    <= '0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_n;
      r_req       <= w_req_n;
      r_addr      <= w_addr_n;
      r_adv       <= w_adv_n;
      r_err       <= w_err_n;
      r_err_pc    <= w_err_pc_n;
      r_buf_instr <= w_buf_instr_n;
      r_buf_pc    <= w_buf_pc_n;
      r_cnt       <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_req_n       = r_req;
    w_addr_n      = r_addr;
    w_adv_n       = 1'b0;
    w_err_n       = r_err;
    w_err_pc_n    = r_err_pc;
    w_buf_instr_n = r_buf_instr;
    w_buf_pc_n    = r_buf_pc;
    w_cnt_n       = r_cnt;
    w_load        = 1'b0;
    w_load_instr  = i_imem_data;
    w_load_pc     = r_addr;
    case (r_state)
      S_IDLE: begin
        if (!i_flush) begin
          if (i_pc[1:0] != 2'b00) begin
            w_err_n    = 1'b1;
            w_err_pc_n = i_pc;
            w_state_n  = S_ERR;
          end else begin
            w_addr_n  = i_pc;
            w_req_n   = 1'b1;
            w_cnt_n   = '0;
            w_state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_imem_ready) begin
          w_req_n = 1'b0;
          if (i_flush) begin
            w_state_n = S_IDLE;
          end else if (w_space) begin
            w_load    = 1'b1;
            w_adv_n   = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_buf_instr_n = i_imem_data;
            w_buf_pc_n    = r_addr;
            w_state_n     = S_HOLD;
          end
        end else if (w_cnt_inc == TO_VAL) begin
          // A fault outranks a concurrent flush: the address is still reported.
          w_req_n    = 1'b0;
          w_err_n    = 1'b1;
          w_err_pc_n = r_addr;
          w_state_n  = S_ERR;
        end else begin
          w_cnt_n = w_cnt_inc;
          if (i_flush) w_state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_imem_ready) begin
          w_req_n   = 1'b0;
          w_state_n = S_IDLE;
        end else if (w_cnt_inc == TO_VAL) begin
          w_req_n    = 1'b0;
          w_err_n    = 1'b1;
          w_err_pc_n = r_addr;
          w_state_n  = S_ERR;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      S_HOLD: begin
        if (i_flush) begin
          w_state_n = S_IDLE;
        end else if (w_space) begin
          w_load       = 1'b1;
          w_load_instr = r_buf_instr;
          w_load_pc    = r_buf_pc;
          w_adv_n      = 1'b1;
          w_state_n    = S_IDLE;
        end
      end
      S_ERR: begin
        w_req_n = 1'b0;
      end
      default: begin
        w_state_n = S_IDLE;
        w_req_n   = 1'b0;
      end
    endcase
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_stall (i_id_stall),
    .i_flush (i_flush),
    .i_instr (w_load_instr),
    .i_pc    (w_load_pc),
    .o_valid (w_if_valid),
    .o_instr (o_if_instr),
    .o_pc    (o_if_pc)
  );

  assign o_if_valid   = w_if_valid;
  assign o_pc_advance = r_adv;
  assign o_imem_req   = r_req;
  assign o_imem_addr  = r_addr;
  assign o_fetch_err  = r_err;
  assign o_err_pc     = r_err_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: normal fetch, stall/hold, flush drain,
// misaligned PC, memory timeout and asynchronous reset mid-transaction.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        id_stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;
  logic [31:0] err_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pc         (pc),
    .o_pc_advance (pc_advance),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_data  (imem_data),
    .i_imem_ready (imem_ready),
    .i_id_stall   (id_stall),
    .i_flush      (flush),
    .o_if_valid   (if_valid),
    .o_if_instr   (if_instr),
    .o_if_pc      (if_pc),
    .o_fetch_err  (fetch_err),
    .o_err_pc     (err_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("comparison %s did not match", tag);
    end
  endtask

  initial begin
    rst = 1'b1; pc = 32'd0; imem_data = 32'd0; imem_ready = 1'b0;
    id_stall = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_adv",   {31'd0, pc_advance}, 32'd0);
    chk("rst_valid", {31'd0, if_valid},   32'd0);
    chk("rst_err",   {31'd0, fetch_err},  32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    chk("rst_instr", if_instr,  32'd0);
    chk("rst_errpc", err_pc,    32'd0);
    rst = 1'b0;

    // Zero-wait fetch of pc=200
    pc = 32'd200;
    tick();
    chk("f1_req",   {31'd0, imem_req},   32'd1);
    chk("f1_addr",  imem_addr,           32'd200);
    chk("f1_valid0",{31'd0, if_valid},   32'd0);
    imem_ready = 1'b1; imem_data = 32'hA000_00C8;
    tick();
    chk("f1_valid", {31'd0, if_valid},   32'd1);
    chk("f1_ifpc",  if_pc,               32'd200);
    chk("f1_instr", if_instr,            32'hA000_00C8);
    chk("f1_adv",   {31'd0, pc_advance}, 32'd1);
    chk("f1_reqlo", {31'd0, imem_req},   32'd0);
    imem_ready = 1'b0; pc = 32'd204;
    tick();
    chk("f2_adv0",  {31'd0, pc_advance}, 32'd0);
    chk("f2_cons",  {31'd0, if_valid},   32'd0);
    chk("f2_addr",  imem_addr,           32'd204);

    // Stall: second fetch lands in the hold buffer
    imem_ready = 1'b1; imem_data = 32'h1111_0001;
    tick();
    chk("s1_ifpc",  if_pc,               32'd204);
    chk("s1_adv",   {31'd0, pc_advance}, 32'd1);
    id_stall = 1'b1; imem_ready = 1'b0; pc = 32'd208;
    tick();
    chk("s2_addr",  imem_addr,           32'd208);
    chk("s2_valid", {31'd0, if_valid},   32'd1);
    imem_ready = 1'b1; imem_data = 32'h2222_0002;
    tick();
    chk("s3_req",   {31'd0, imem_req},   32'd0);
    chk("s3_adv",   {31'd0, pc_advance}, 32'd0);
    chk("s3_ifpc",  if_pc,               32'd204);
    chk("s3_instr", if_instr,            32'h1111_0001);
    imem_ready = 1'b0;
    tick();
    chk("s4_hold",  if_instr,            32'h1111_0001);
    chk("s4_adv",   {31'd0, pc_advance}, 32'd0);
    id_stall = 1'b0;
    tick();
    chk("s5_ifpc",  if_pc,               32'd208);
    chk("s5_instr", if_instr,            32'h2222_0002);
    chk("s5_adv",   {31'd0, pc_advance}, 32'd1);
    pc = 32'd204;
    tick();
    chk("s6_adv0",  {31'd0, pc_advance}, 32'd0);
    chk("s6_req",   {31'd0, imem_req},   32'd1);
    chk("s6_addr",  imem_addr,           32'd204);

    // Flush during a 3-wait-cycle fetch
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl1_req",  {31'd0, imem_req},   32'd1);
    chk("fl1_valid",{31'd0, if_valid},   32'd0);
    tick(); tick();
    chk("fl2_req",  {31'd0, imem_req},   32'd1);
    imem_ready = 1'b1; imem_data = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    chk("fl3_req",  {31'd0, imem_req},   32'd0);
    chk("fl3_adv",  {31'd0, pc_advance}, 32'd0);
    chk("fl3_valid",{31'd0, if_valid},   32'd0);
    tick();
    chk("fl4_req",  {31'd0, imem_req},   32'd1);
    chk("fl4_addr", imem_addr,           32'd204);
    imem_ready = 1'b1; imem_data = 32'h3333_0003;
    tick();
    imem_ready = 1'b0;
    chk("fl5_instr",if_instr,            32'h3333_0003);
    chk("fl5_adv",  {31'd0, pc_advance}, 32'd1);

    // Misaligned PC
    pc = 32'd202;
    tick();
    chk("m1_req",   {31'd0, imem_req},   32'd0);
    chk("m1_err",   {31'd0, fetch_err},  32'd1);
    chk("m1_errpc", err_pc,              32'd202);
    pc = 32'd200;
    tick(); tick(); tick();
    chk("m2_err",   {31'd0, fetch_err},  32'd1);
    chk("m2_req",   {31'd0, imem_req},   32'd0);
    chk("m2_adv",   {31'd0, pc_advance}, 32'd0);
    rst = 1'b1;
    #1;
    chk("m3_errclr",{31'd0, fetch_err},  32'd0);
    chk("m3_errpc", err_pc,              32'd0);
    tick();

    // Timeout with imem_ready held low
    pc = 32'd208;
    rst = 1'b0;
    tick();
    chk("t1_req",   {31'd0, imem_req},   32'd1);
    repeat (15) tick();
    chk("t2_req",   {31'd0, imem_req},   32'd1);
    chk("t2_err",   {31'd0, fetch_err},  32'd0);
    tick();
    chk("t3_err",   {31'd0, fetch_err},  32'd1);
    chk("t3_errpc", err_pc,              32'd208);
    chk("t3_req",   {31'd0, imem_req},   32'd0);

    // Asynchronous reset mid-WAIT
    rst = 1'b1;
    tick();
    pc = 32'd212;
    rst = 1'b0;
    tick();
    chk("r1_addr",  imem_addr,           32'd212);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("r2_req",   {31'd0, imem_req},   32'd0);
    chk("r2_addr",  imem_addr,           32'd0);
    chk("r2_err",   {31'd0, fetch_err},  32'd0);
    #1;
    rst = 1'b0;
    pc = 32'd216;
    tick();
    chk("r3_req",   {31'd0, imem_req},   32'd1);
    chk("r3_addr",  imem_addr,           32'd216);
    imem_ready = 1'b1; imem_data = 32'h4444_0004;
    tick();
    imem_ready = 1'b0;
    chk("r4_ifpc",  if_pc,               32'd216);
    chk("r4_instr", if_instr,            32'h4444_0004);
    chk("r4_adv",   {31'd0, pc_advance}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
